pipeline_stall_controller: RTL

PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_stall_controller.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding and
// default sizing of the performance counters and the memory-wait timeout.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEFAULT       = 16;
  localparam int MEM_TIMEOUT_DEFAULT = 63;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: registers are written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/stall controller: memory-wait freeze with timeout abort,
// branch flush and load-use hazard stall, plus stall/flush performance counters.
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_start,
  output logic             freeze_all,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_bubble,
  output logic             flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // wait_cnt reads 0 in the first MEM_WAIT cycle, so the last permitted
  // cycle (the MEM_TIMEOUT-th) is the one where it equals MEM_TIMEOUT-1.
  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              abort;
  logic              hazard_stall;

  // NOTE: every output of this block is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    abort        = (state == MEM_WAIT) && !mem_ready && (wait_cnt == WAIT_LAST);
    mem_start    = (state == RUN) && mem_req;
    freeze_all   = ((state == RUN) && mem_req && !mem_ready) ||
                   ((state == MEM_WAIT) && !mem_ready && !abort);
    flush        = branch_taken && !freeze_all;
    hazard_stall = hazard_detected && !branch_taken && !freeze_all;
    pc_freeze     = hazard_stall;
    if_id_freeze  = hazard_stall;
    id_exe_bubble = hazard_stall;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready || abort) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
      endcase
      if (abort) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (freeze_all || pc_freeze),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush),
    .count (flush_count)
  );

endmodule
